divider: RTL and testbench
==========================

DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have port Clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port Reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL have port Run, input, 1, start request, level-sampled in IDLE.
REQ-004 SHALL have port Dividend, input, 8, numerator, captured on start.
REQ-005 SHALL have port Divisor, input, 8, denominator, captured on start.
REQ-006 SHALL have port Quotient, output, 8, result quotient, registered.
REQ-007 SHALL have port Remainder, output, 8, result remainder, registered.
REQ-008 SHALL have port Busy, output, 1, high in every state except IDLE and DONE.
REQ-009 SHALL have port Done, output, 1, high exactly while in DONE.
REQ-010 SHALL have port DivZero, output, 1, high in DONE when the captured Divisor was zero.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, FIX (only with DIVIDER_SIGNED_EN), DONE.
REQ-012 SHALL transition IDLE->CALC when Run=1: Dividend to Q register, Divisor to D register, 9-bit partial remainder R=0, 3-bit counter=0.
REQ-013 SHALL transition IDLE->DONE instead when Run=1 and Divisor=0: Quotient=8'hFF, Remainder=Dividend, DivZero=1.
REQ-014 SHALL, per CALC cycle: form T = {R[7:0],Q[7]} minus {1'b0,D} using a 9-bit add/subtract (add ~D, carry-in 1).
 - If T[8]=0: R=T, Q={Q[6:0],1}.
 - Else: R={R[7:0],Q[7]}, Q={Q[6:0],0}.
REQ-015 SHALL increment the counter each CALC cycle and leave CALC after exactly 8 cycles: to FIX if signed, else to DONE.
REQ-016 SHALL load Quotient=Q and Remainder=R[7:0] on entry to DONE; both hold until the next start or Reset.
REQ-017 SHALL latency: Run sampled at edge N gives Done=1 from edge N+9 (unsigned) or N+10 (signed); DivZero case gives Done=1 from edge N+1.
REQ-018 SHALL stay in DONE while Run=1 and go DONE->IDLE on the first cycle Run=0; a held Run never starts a second operation.
REQ-019 SHALL ignore Run, Dividend and Divisor changes while in CALC or FIX.
REQ-020 SHALL clear DivZero on the next start.

Reset
REQ-021 SHALL, when Reset=1 at a rising edge, in any state including mid-CALC:
 - state=IDLE; Quotient=0, Remainder=0; Busy=0, Done=0, DivZero=0; counter=0, R=0.
REQ-022 SHALL give Reset priority over Run in the same cycle.

Configuration
REQ-023 SHALL, with macro DIVIDER_SIGNED_EN defined, treat Dividend and Divisor as two's complement:
 - Divide magnitudes in CALC.
 - In FIX, negate the quotient if operand signs differ and negate the remainder if Dividend<0 (truncation toward zero).
 - -128 / -1 yields Quotient=8'h80, Remainder=0.
REQ-024 SHALL, without DIVIDER_SIGNED_EN, be unsigned only, with no FIX state and no extra cycle.

Verification
REQ-025 SHALL cover: Dividend=100, Divisor=7, Run pulse at edge 0 -> Done=1 at edge 9, Quotient=14, Remainder=2, DivZero=0.
REQ-026 SHALL cover: Dividend=255, Divisor=1 -> Quotient=255, Remainder=0; then Dividend=3, Divisor=200 -> Quotient=0, Remainder=3.
REQ-027 SHALL cover: Dividend=5, Divisor=0 -> Done=1 and DivZero=1 at edge 1, Quotient=8'hFF, Remainder=5; next valid start clears DivZero.
REQ-028 SHALL cover: Run held high 20 cycles -> exactly one operation, Done held until Run=0, then IDLE with Busy=0.
REQ-029 SHALL cover: Reset asserted at CALC cycle 4 -> next edge IDLE with all outputs 0; a new start completes correctly.
REQ-030 SHALL cover, with DIVIDER_SIGNED_EN: Dividend=-7 (8'hF9), Divisor=2 -> Done at edge 10, Quotient=8'hFD, Remainder=8'hFF; and -128/-1 -> 8'h80, 0.

Source files
------------

// File: rtl/divider.sv
// divider: 8-bit iterative restoring divider, one quotient bit per cycle.
// Optional signed mode is enabled by defining DIVIDER_SIGNED_EN; without it
// the block is unsigned only and has no FIX state.
module divider (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic [7:0] Dividend,
    input  logic [7:0] Divisor,
    output logic [7:0] Quotient,
    output logic [7:0] Remainder,
    output logic       Busy,
    output logic       Done,
    output logic       DivZero
);

`ifdef DIVIDER_SIGNED_EN
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`endif

    state_t      state_q, state_d;
    logic [7:0]  qreg_q, qreg_d;     // shifting dividend / quotient register
    logic [7:0]  dreg_q, dreg_d;     // captured divisor (magnitude)
    // The partial remainder always stays below the divisor, so its ninth bit
    // is constantly zero and only the low byte needs to be stored.
    logic [7:0]  rem_q, rem_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  quot_q, quot_d;
    logic [7:0]  remo_q, remo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        dz_q, dz_d;
    logic [8:0]  shift;
    logic [8:0]  trial;
`ifdef DIVIDER_SIGNED_EN
    logic        qneg_q, qneg_d;     // quotient must be negated in FIX
    logic        rneg_q, rneg_d;     // remainder must be negated in FIX
`endif

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d = state_q;
        qreg_d  = qreg_q;
        dreg_d  = dreg_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        busy_d  = busy_q;
        done_d  = done_q;
        dz_d    = dz_q;
`ifdef DIVIDER_SIGNED_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif
        shift = {rem_q, qreg_q[7]};
        trial = shift + {1'b1, ~dreg_q} + 9'd1;

        case (state_q)
            IDLE: begin
                if (Run) begin
                    if (Divisor == '0) begin
                        state_d = DONE;
                        quot_d  = '1;
                        remo_d  = Dividend;
                        dz_d    = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = CALC;
`ifdef DIVIDER_SIGNED_EN
                        qreg_d  = Dividend[7] ? (~Dividend + 8'd1) : Dividend;
                        dreg_d  = Divisor[7]  ? (~Divisor + 8'd1)  : Divisor;
                        qneg_d  = Dividend[7] ^ Divisor[7];
                        rneg_d  = Dividend[7];
`else
                        qreg_d  = Dividend;
                        dreg_d  = Divisor;
`endif
                        rem_d   = '0;
                        cnt_d   = '0;
                        dz_d    = 1'b0;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                    end
                end
            end
            CALC: begin
                if (!trial[8]) begin
                    rem_d  = trial[7:0];
                    qreg_d = {qreg_q[6:0], 1'b1};
                end else begin
                    rem_d  = shift[7:0];
                    qreg_d = {qreg_q[6:0], 1'b0};
                end
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
`ifdef DIVIDER_SIGNED_EN
                    state_d = FIX;
`else
                    state_d = DONE;
                    quot_d  = qreg_d;
                    remo_d  = rem_d;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`endif
                end
            end
`ifdef DIVIDER_SIGNED_EN
            FIX: begin
                state_d = DONE;
                quot_d  = qneg_q ? (~qreg_q + 8'd1) : qreg_q;
                remo_d  = rneg_q ? (~rem_q + 8'd1) : rem_q;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
`endif
            DONE: begin
                if (!Run) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            qreg_q  <= '0;
            dreg_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            remo_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            qreg_q  <= qreg_d;
            dreg_q  <= dreg_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
`ifdef DIVIDER_SIGNED_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    assign Quotient  = quot_q;
    assign Remainder = remo_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign DivZero   = dz_q;

endmodule

// File: tb/tb_divider.sv
// tb_divider: directed and random checks of divider against an arithmetic
// reference model (a/b, a%b). Honours DIVIDER_SIGNED_EN when defined.
module tb_divider;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Run;
    logic [7:0] Dividend;
    logic [7:0] Divisor;
    logic [7:0] Quotient;
    logic [7:0] Remainder;
    logic       Busy;
    logic       Done;
    logic       DivZero;

    int nvec = 0;
    int nerr = 0;

`ifdef DIVIDER_SIGNED_EN
    localparam int LAT = 10;
`else
    localparam int LAT = 9;
`endif

    divider dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Run       (Run),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Busy      (Busy),
        .Done      (Done),
        .DivZero   (DivZero)
    );

    always #5 Clk = ~Clk;

    task tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero when signed.
    task automatic model(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r);
        int sa, sb, qi, ri;
        if (b == 8'd0) begin
            q = 8'hFF;
            r = a;
        end else begin
`ifdef DIVIDER_SIGNED_EN
            sa = int'($signed(a));
            sb = int'($signed(b));
`else
            sa = int'(a);
            sb = int'(b);
`endif
            qi = sa / sb;
            ri = sa % sb;
            q  = qi[7:0];
            r  = ri[7:0];
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input string tag);
        logic [7:0] eq, er;
        int         lat;
        logic       busy_ok;
        model(a, b, eq, er);
        Dividend = a;
        Divisor  = b;
        Run      = 1'b1;
        tick;
        Run      = 1'b0;
        Dividend = 8'($urandom);
        Divisor  = 8'($urandom);
        check({tag, " divzero_at_start"}, DivZero, (b == 8'd0));
        lat     = 1;
        busy_ok = 1'b1;
        while (!Done && lat < 30) begin
            if (Busy !== 1'b1) busy_ok = 1'b0;
            tick;
            lat++;
        end
        check({tag, " latency"}, lat, (b == 8'd0) ? 1 : LAT);
        check({tag, " busy_while_calc"}, busy_ok, 1'b1);
        check({tag, " quotient"}, Quotient, eq);
        check({tag, " remainder"}, Remainder, er);
        check({tag, " divzero"}, DivZero, (b == 8'd0));
        check({tag, " busy_in_done"}, Busy, 1'b0);
        tick;
        check({tag, " done_cleared"}, Done, 1'b0);
        check({tag, " quotient_hold"}, Quotient, eq);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [7:0] eq, er, a, b;
        int         starts;
        logic       prev_busy;

        Reset    = 1'b1;
        Run      = 1'b0;
        Dividend = '0;
        Divisor  = '0;
        tick;
        tick;
        Reset = 1'b0;
        check("reset quotient", Quotient, 8'h00);
        check("reset remainder", Remainder, 8'h00);
        check("reset busy", Busy, 1'b0);
        check("reset done", Done, 1'b0);
        check("reset divzero", DivZero, 1'b0);

        run_op(8'd100, 8'd7, "d100_7");
        run_op(8'd255, 8'd1, "d255_1");
        run_op(8'd3, 8'd200, "d3_200");
        run_op(8'd5, 8'd0, "d5_0");
        run_op(8'd9, 8'd3, "d9_3");

        // Run held high for 20 cycles: only one operation may start.
        model(8'd200, 8'd9, eq, er);
        Dividend  = 8'd200;
        Divisor   = 8'd9;
        Run       = 1'b1;
        starts    = 0;
        prev_busy = Busy;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (Busy && !prev_busy) starts++;
            prev_busy = Busy;
        end
        check("held starts", starts, 1);
        check("held done", Done, 1'b1);
        check("held quotient", Quotient, eq);
        check("held remainder", Remainder, er);
        Run = 1'b0;
        tick;
        check("held release done", Done, 1'b0);
        check("held release busy", Busy, 1'b0);
        tick;
        check("held idle busy", Busy, 1'b0);

        // Reset in the middle of CALC.
        Dividend = 8'd77;
        Divisor  = 8'd5;
        Run      = 1'b1;
        tick;
        Run = 1'b0;
        repeat (4) tick;
        check("midreset busy_before", Busy, 1'b1);
        Reset = 1'b1;
        tick;
        Reset = 1'b0;
        check("midreset quotient", Quotient, 8'h00);
        check("midreset remainder", Remainder, 8'h00);
        check("midreset busy", Busy, 1'b0);
        check("midreset done", Done, 1'b0);
        check("midreset divzero", DivZero, 1'b0);
        run_op(8'd77, 8'd5, "after_reset");

        // Reset wins over Run in the same cycle.
        Dividend = 8'd50;
        Divisor  = 8'd4;
        Run      = 1'b1;
        Reset    = 1'b1;
        tick;
        Reset = 1'b0;
        Run   = 1'b0;
        check("reset_prio busy", Busy, 1'b0);
        check("reset_prio done", Done, 1'b0);

`ifdef DIVIDER_SIGNED_EN
        run_op(8'hF9, 8'd2, "s_m7_2");
        check("s_m7_2 q_const", Quotient, 8'hFD);
        check("s_m7_2 r_const", Remainder, 8'hFF);
        run_op(8'h80, 8'hFF, "s_m128_m1");
        check("s_m128_m1 q_const", Quotient, 8'h80);
        check("s_m128_m1 r_const", Remainder, 8'h00);
`endif

        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            run_op(a, b, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
